spi_flash_slave: RTL and testbench

Serial-flash target that sits directly downstream of the SPI master's pins (`spi_sck`, `spi_ss[0]`, `spi_mosi`, `spi_miso`) and services its XIP read sequence: command 0x03, 24-bit address, then data. It samples SPI on the system clock, fetches 32-bit words from a synchronous backing memory, and shifts bytes back MSB-first. Used as the flash model behind the XIP window in simulation and FPGA builds.

---
 rtl/spi_flash_pkg.sv | 27 ++
 rtl/spi_flash_slave_edge_detect.sv | 64 ++++++
 rtl/spi_flash_slave.sv | 199 +++++++++++++++++++
 tb/tb_spi_flash_slave.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI serial-flash read target.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_FETCH,
        ST_DATA,
        ST_IGNORE
    } state_t;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam logic [7:0] READ_CMD = 8'h03;
    localparam int CNT_W = $clog2(ADDR_BITS);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);

    // Byte n of a memory word sits at bits [8n+7:8n].
    function automatic logic [7:0] word_lane(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/spi_flash_slave_edge_detect.sv
// SPI pin conditioning: optional 2-flop synchronizers (SPI_FLASH_SYNC_EN) and
// single-cycle rise/fall pulses for spi_sck and spi_ss.
module spi_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic spi_sck,
    input  logic spi_ss,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic ss_level,
    output logic mosi_level
);

    logic [2:0] pins;
    logic [2:0] pins_in;
    logic       sck_prev_reg;
    logic       ss_prev_reg;

    assign pins = {spi_mosi, spi_ss, spi_sck};

`ifdef SPI_FLASH_SYNC_EN
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= pins[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign pins_in[gi] = s2_reg;
        end
    endgenerate
`else
    assign pins_in = pins;
`endif

    // ss history resets low so a chip select held low through reset
    // must go high and fall again before a command is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_prev_reg <= 1'b0;
            ss_prev_reg  <= 1'b0;
        end else begin
            sck_prev_reg <= pins_in[0];
            ss_prev_reg  <= pins_in[1];
        end
    end

    assign sck_rise   =  pins_in[0] & ~sck_prev_reg;
    assign sck_fall   = ~pins_in[0] &  sck_prev_reg;
    assign ss_fall    = ~pins_in[1] &  ss_prev_reg;
    assign ss_rise    =  pins_in[1] & ~ss_prev_reg;
    assign ss_level   =  pins_in[1];
    assign mosi_level =  pins_in[2];

endmodule

// File: rtl/spi_flash_slave.sv
// SPI flash read target (opcode + 24-bit address, streaming data with word prefetch).
// Define SPI_FLASH_SYNC_EN to synchronize the SPI pins for asynchronous stimulus.
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter int         addr_width = 24,
    parameter logic [7:0] read_cmd   = READ_CMD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  spi_sck,
    input  logic                  spi_ss,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  mem_req,
    output logic [addr_width-3:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [ADDR_BITS-2:0]  shift_reg;
    logic [addr_width-3:0] word_addr_reg;
    logic [addr_width-3:0] mem_addr_reg;
    logic [1:0]            lane_reg;
    logic [1:0]            pf_stage_reg;
    logic [31:0]           cur_word_reg;
    logic [31:0]           next_word_reg;
    logic [7:0]            out_reg;
    logic                  mem_req_reg;
    logic                  skip_reg;
    logic                  fall_seen_reg;

    logic sck_rise, sck_fall, ss_fall, ss_rise, ss_level, mosi_level;
    logic deselect;
    logic cmd_done, addr_done, fetch_ready, byte_done;
    logic [CMD_BITS-1:0]  cmd_word;
    logic [ADDR_BITS-1:0] addr_full;
    logic [7:0]           next_byte;

    spi_edge_detect u_edge (
        .clock      (clock),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_ss     (spi_ss),
        .spi_mosi   (spi_mosi),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall),
        .ss_fall    (ss_fall),
        .ss_rise    (ss_rise),
        .ss_level   (ss_level),
        .mosi_level (mosi_level)
    );

    assign deselect    = ss_level | ss_rise;
    assign cmd_word    = {shift_reg[CMD_BITS-2:0], mosi_level};
    assign addr_full   = {shift_reg, mosi_level};
    assign cmd_done    = sck_rise && (bit_cnt_reg == CMD_LAST);
    assign addr_done   = sck_rise && (bit_cnt_reg == ADDR_LAST);
    assign fetch_ready = bit_cnt_reg[0];
    assign byte_done   = (bit_cnt_reg == BYTE_LAST);
    assign next_byte   = (lane_reg == 2'd3) ? next_word_reg[7:0]
                                            : word_lane(cur_word_reg, lane_reg + 2'd1);

    always_ff @(posedge clock) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (deselect) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (ss_fall)     state_next = ST_CMD;
                ST_CMD:   if (cmd_done)    state_next = (cmd_word == read_cmd) ? ST_ADDR : ST_IGNORE;
                ST_ADDR:  if (addr_done)   state_next = ST_FETCH;
                ST_FETCH: if (fetch_ready) state_next = ST_DATA;
                default:  ;
            endcase
        end
    end

    always_comb begin
        busy = !ss_level && (state_reg != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            word_addr_reg <= '0;
            mem_addr_reg  <= '0;
            lane_reg      <= '0;
            pf_stage_reg  <= '0;
            cur_word_reg  <= '0;
            next_word_reg <= '0;
            out_reg       <= '0;
            mem_req_reg   <= 1'b0;
            skip_reg      <= 1'b0;
            fall_seen_reg <= 1'b0;
        end else begin
            mem_req_reg <= 1'b0;
            if (deselect) begin
                bit_cnt_reg   <= '0;
                shift_reg     <= '0;
                out_reg       <= '0;
                pf_stage_reg  <= '0;
                skip_reg      <= 1'b0;
                fall_seen_reg <= 1'b0;
            end else begin
                // Prefetch read data is valid two cycles after the request is registered.
                if (pf_stage_reg == 2'd1) begin
                    pf_stage_reg <= 2'd2;
                end else if (pf_stage_reg == 2'd2) begin
                    next_word_reg <= mem_rdata;
                    pf_stage_reg  <= 2'd0;
                end
                case (state_reg)
                    ST_IDLE: begin
                        if (ss_fall) begin
                            bit_cnt_reg <= '0;
                            shift_reg   <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            shift_reg   <= {shift_reg[ADDR_BITS-3:0], mosi_level};
                            bit_cnt_reg <= cmd_done ? '0 : bit_cnt_reg + 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            shift_reg <= {shift_reg[ADDR_BITS-3:0], mosi_level};
                            if (addr_done) begin
                                bit_cnt_reg   <= '0;
                                word_addr_reg <= addr_full[addr_width-1:2];
                                mem_addr_reg  <= addr_full[addr_width-1:2];
                                lane_reg      <= addr_full[1:0];
                                mem_req_reg   <= 1'b1;
                                fall_seen_reg <= 1'b0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (sck_fall) fall_seen_reg <= 1'b1;
                        if (!fetch_ready) begin
                            bit_cnt_reg <= CNT_W'(1);
                        end else begin
                            cur_word_reg <= mem_rdata;
                            out_reg      <= word_lane(mem_rdata, lane_reg);
                            bit_cnt_reg  <= '0;
                            // The falling edge that presents the first bit must not shift it out.
                            skip_reg     <= !(fall_seen_reg || sck_fall);
                            if (lane_reg == 2'd3) begin
                                mem_req_reg  <= 1'b1;
                                mem_addr_reg <= word_addr_reg + 1'b1;
                                pf_stage_reg <= 2'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_fall) begin
                            if (skip_reg) begin
                                skip_reg <= 1'b0;
                            end else if (!byte_done) begin
                                out_reg     <= {out_reg[6:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end else begin
                                out_reg     <= next_byte;
                                bit_cnt_reg <= '0;
                                lane_reg    <= lane_reg + 2'd1;
                                if (lane_reg == 2'd3) begin
                                    cur_word_reg  <= next_word_reg;
                                    word_addr_reg <= word_addr_reg + 1'b1;
                                end
                                if (lane_reg == 2'd2) begin
                                    mem_req_reg  <= 1'b1;
                                    mem_addr_reg <= word_addr_reg + 1'b1;
                                    pf_stage_reg <= 2'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi_miso = out_reg[7];
    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_spi_flash_slave.sv
// Self-checking bench: bit-banged SPI master against a byte-addressed flash model.
module tb_spi_flash_slave;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    int half   = 2;
    int consec = 0;
    logic        req_prev = 1'b0;
    logic [21:0] req_q[$];
    logic [21:0] exp_req_q[$];
    logic [7:0]  got_q[$];

    always #5 clock = ~clock;

    spi_flash_slave #(.addr_width(24), .read_cmd(8'h03)) dut (
        .clock     (clock),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        case (a)
            22'h000000: return 32'h44332211;
            22'h000001: return 32'h88776655;
            22'h3FFFFF: return 32'hDDCCBBAA;
            default:    return {a[7:0], ~a[7:0], a[15:8], a[21:14]} ^ 32'h1234_5678;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input logic [23:0] b);
        logic [31:0] w;
        w = mem_word(b[23:2]);
        case (b[1:0])
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    // Word reads expected: the start word, then one per lane-3 byte that gets driven.
    // The fall after the last sampled bit drives one byte beyond those read.
    task automatic build_exp_reqs(input logic [23:0] addr, input int nbytes);
        logic [23:0] b;
        exp_req_q.delete();
        exp_req_q.push_back(addr[23:2]);
        for (int k = 0; k <= nbytes; k++) begin
            b = addr + 24'(k);
            if (b[1:0] == 2'd3) exp_req_q.push_back(b[23:2] + 22'd1);
        end
    endtask

    // Memory: registered read, data valid the cycle after mem_req; otherwise noise.
    always @(posedge clock) mem_rdata <= mem_req ? mem_word(mem_addr) : $urandom;

    always @(negedge clock) begin
        if (mem_req) begin
            req_q.push_back(mem_addr);
            if (req_prev) consec++;
        end
        req_prev = mem_req;
    end

    task automatic spi_begin();
        @(negedge clock);
        spi_sck = 1'b0;
        spi_ss  = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = v[i];
            repeat (half) @(negedge clock);
            spi_sck = 1'b1;
            repeat (half) @(negedge clock);
            spi_sck = 1'b0;
        end
    endtask

    task automatic read_bits(input int n, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < n; i++) begin
            repeat (half) @(negedge clock);
            b = {b[6:0], spi_miso};
            spi_sck = 1'b1;
            repeat (half) @(negedge clock);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_end();
        repeat (half) @(negedge clock);
        spi_ss = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic run_read(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
        logic [7:0] b;
        got_q.delete();
        req_q.delete();
        spi_begin();
        send_bits({cmd, addr}, 32);
        for (int i = 0; i < nbytes; i++) begin
            read_bits(8, b);
            got_q.push_back(b);
        end
        spi_end();
        $display("xfer cmd=%02h addr=%06h bytes=%0d half=%0d reqs=%0d", cmd, addr, nbytes, half, req_q.size());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        spi_ss = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (spi_miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 22'h0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_read(input string name, input logic [23:0] addr, input int nbytes);
        bit ok;
        run_read(8'h03, addr, nbytes);
        build_exp_reqs(addr, nbytes);
        for (int i = 0; i < nbytes; i++) begin
            checks++;
            if (got_q[i] !== exp_byte(addr + 24'(i))) begin
                fails++;
                $display("FAIL %s byte%0d: got %02h expected %02h", name, i, got_q[i], exp_byte(addr + 24'(i)));
            end
        end
        ok = (req_q.size() == exp_req_q.size());
        foreach (exp_req_q[i]) if (ok && req_q[i] !== exp_req_q[i]) ok = 0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s mem_req: got %0d reqs first %h, expected %0d reqs first %h",
                     name, req_q.size(), (req_q.size() > 0) ? req_q[0] : 22'h0, exp_req_q.size(), exp_req_q[0]);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] b;
        req_q.delete();
        spi_begin();
        send_bits({8'h9F, 24'h000000}, 32);
        for (int i = 0; i < 4; i++) begin
            read_bits(8, b);
            checks++; if (b !== 8'h00) begin fails++; $display("FAIL badcmd_miso%0d: got %02h expected 00", i, b); end
        end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL badcmd_busy: got %b expected 1", busy); end
        spi_end();
        $display("xfer cmd=9f addr=000000 bytes=4 half=%0d reqs=%0d", half, req_q.size());
        checks++; if (req_q.size() != 0) begin fails++; $display("FAIL badcmd_req: got %0d reqs expected 0", req_q.size()); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL badcmd_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_abort_restart();
        logic [7:0] b;
        spi_begin();
        send_bits({8'h03, 24'h000000}, 32);
        read_bits(8, b);
        checks++; if (b !== exp_byte(24'h0)) begin fails++; $display("FAIL abort_first: got %02h expected %02h", b, exp_byte(24'h0)); end
        read_bits(4, b);
        spi_end();
        $display("xfer cmd=03 addr=000000 bits=12 half=%0d (deselect)", half);
        run_read(8'h03, 24'h000004, 2);
        checks++; if (got_q[0] !== 8'h55) begin fails++; $display("FAIL restart_byte0: got %02h expected 55", got_q[0]); end
        checks++; if (got_q[1] !== exp_byte(24'h5)) begin fails++; $display("FAIL restart_byte1: got %02h expected %02h", got_q[1], exp_byte(24'h5)); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        spi_begin();
        send_bits({8'h03, 24'h000010}, 32);
        read_bits(8, b);
        read_bits(3, b);
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (spi_miso !== 1'b0) begin fails++; $display("FAIL midrst_miso: got %b expected 0", spi_miso); end
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL midrst_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 22'h0) begin fails++; $display("FAIL midrst_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        @(negedge clock);
        reset = 1'b0;
        req_q.delete();
        send_bits({8'h03, 24'h000010}, 32);
        repeat (4) @(negedge clock);
        checks++; if (req_q.size() != 0 || busy !== 1'b0) begin
            fails++; $display("FAIL midrst_no_toggle: got reqs=%0d busy=%b expected reqs=0 busy=0", req_q.size(), busy);
        end
        spi_end();
        $display("xfer reset mid-data then command without ss toggle");
        test_read("after_reset", 24'h000010, 4);
    endtask

    task automatic test_random();
        logic [23:0] addr;
        int nbytes;
        for (int t = 0; t < 10; t++) begin
            half   = int'($urandom_range(2, 4));
            addr   = 24'($urandom);
            if (t % 3 == 0) addr = 24'hFFFFF8 | 24'($urandom_range(0, 7));
            nbytes = int'($urandom_range(1, 10));
            test_read("random", addr, nbytes);
        end
        half = 2;
    endtask

    initial begin
        test_reset();
        test_read("aligned", 24'h000000, 8);
        test_read("unaligned", 24'h000002, 4);
        test_read("wrap", 24'hFFFFFC, 8);
        test_bad_cmd();
        test_abort_restart();
        test_reset_mid();
        test_random();
        checks++; if (consec != 0) begin fails++; $display("FAIL mem_req_consecutive: got %0d back-to-back pulses expected 0", consec); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
